keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator_pkg.sv | 26 ++
 rtl/keypad_emulator_bounce_lfsr.sv | 37 +++
 rtl/keypad_emulator.sv | 160 ++++++++++++++++
 tb/tb_keypad_emulator.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_emulator_pkg.sv
// Shared definitions for the keypad emulator.
//   - state_e   : press-sequence state encoding
//   - KEY_W     : key-index width (2 row bits + 2 column bits)
//   - LFSR_*    : chatter generator width, reset seed and tap mask
//   - lfsr_step : one Fibonacci step, x^8 + x^6 + x^5 + x^4 + 1
package keypad_emulator_pkg;

    localparam int         KEY_W     = 4;
    localparam int         LFSR_W    = 8;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps at stages 8, 6, 5, 4 -> state bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE           = 2'd0,
        ST_PRESS_BOUNCE   = 2'd1,
        ST_HOLD           = 2'd2,
        ST_RELEASE_BOUNCE = 2'd3
    } state_e;

    // Shift left and insert the XOR of the tapped bits at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/keypad_emulator_bounce_lfsr.sv
// bounce_lfsr: 8-bit Fibonacci LFSR that supplies contact-chatter bits.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset, loads LFSR_SEED
//   en      : advance one step on this clock edge
//   state_o : current LFSR state
// A maximal-length polynomial started from a non-zero seed never reaches
// the all-zero lock-up state.
module bounce_lfsr
    import keypad_emulator_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: emulates one key of a 4x4 matrix keypad, including
// contact chatter, for exercising a keypad scanner.
//   clk       : system clock, all state on the rising edge
//   RSTn      : asynchronous active-low reset
//   row       : scan row drive from the scanner, active-low
//   col       : column return to the scanner, active-low, 4'hF when open
//   cmd_valid : press command valid
//   cmd_ready : command accepted (only in IDLE)
//   cmd_key   : key index, row = [3:2], column = [1:0]
//   cmd_hold  : stable-closed time in ticks (0 behaves as 1)
//   busy      : press sequence in progress
//   done      : one-cycle pulse on the last cycle of a sequence
module keypad_emulator
    import keypad_emulator_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BOUNCE_TICKS = 5
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [KEY_W-1:0] cmd_key,
    input  logic [15:0]      cmd_hold,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(TICK_DIV);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;       // prescaler
    logic [15:0]        tcnt_q, tcnt_d;     // ticks spent in current state
    logic               contact_q, contact_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [15:0]        hold_q, hold_d;

    logic [LFSR_W-1:0]  lfsr_state;
    logic               lfsr_en;
    logic               bounce_bit;
    logic               accept;
    logic               tick;
    logic [15:0]        hold_eff;
    logic               bounce_last;
    logic               hold_last;

    bounce_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (RSTn),
        .en      (lfsr_en),
        .state_o (lfsr_state)
    );

    // Chatter bit; forced open if the generator were ever locked at zero.
    assign bounce_bit  = lfsr_state[0] && (lfsr_state != '0);
    assign accept      = cmd_valid && cmd_ready;
    assign tick        = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign hold_eff    = (hold_q == 16'd0) ? 16'd1 : hold_q;
    assign bounce_last = tick && (tcnt_q == 16'(BOUNCE_TICKS - 1));
    assign hold_last   = tick && (tcnt_q == hold_eff - 16'd1);

    // State register
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            contact_q <= 1'b0;
            key_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            contact_q <= contact_d;
            key_q     <= key_d;
            hold_q    <= hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        tcnt_d    = tick ? tcnt_q + 16'd1 : tcnt_q;
        contact_d = contact_q;
        key_d     = key_q;
        hold_d    = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                if (accept) begin
                    key_d  = cmd_key;
                    hold_d = cmd_hold;
                    cnt_d  = '0;     // tick phase starts from the accept
                    if (BOUNCE_TICKS == 0) begin
                        state_d   = ST_HOLD;
                        contact_d = 1'b1;
                    end else begin
                        state_d   = ST_PRESS_BOUNCE;
                        contact_d = 1'b0;
                    end
                end
            end
            ST_PRESS_BOUNCE: begin
                if (tick) begin
                    contact_d = bounce_bit;
                    if (bounce_last) begin
                        state_d   = ST_HOLD;
                        contact_d = 1'b1;
                        tcnt_d    = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_last) begin
                    tcnt_d = '0;
                    if (BOUNCE_TICKS == 0) begin
                        state_d   = ST_IDLE;
                        contact_d = 1'b0;
                    end else begin
                        state_d = ST_RELEASE_BOUNCE;
                    end
                end
            end
            ST_RELEASE_BOUNCE: begin
                if (tick) begin
                    contact_d = bounce_bit;
                    if (bounce_last) begin
                        state_d   = ST_IDLE;
                        contact_d = 1'b0;
                        tcnt_d    = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs. done is raised on the final busy cycle so it never
    // coincides with cmd_ready.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        lfsr_en   = tick && ((state_q == ST_PRESS_BOUNCE) ||
                             (state_q == ST_RELEASE_BOUNCE));
        done      = ((state_q == ST_RELEASE_BOUNCE) && bounce_last) ||
                    ((state_q == ST_HOLD) && hold_last && (BOUNCE_TICKS == 0));
    end

    // Switch model: row-to-col path is purely combinational.
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign col[gi] = !(contact_q && (key_q[1:0] == 2'(gi)) && !row[key_q[3:2]]);
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with TICK_DIV = 4.
// Instance A has no chatter, instance B has 5 ticks of chatter.
// Inputs are driven just after the falling edge, outputs sampled 1 ns later.
module tb_keypad_emulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_a, col_a, row_b, col_b;
    logic        a_valid, a_ready, a_busy, a_done;
    logic        b_valid, b_ready, b_busy, b_done;
    logic [3:0]  a_key, b_key;
    logic [15:0] a_hold, b_hold;

    int checks   = 0;
    int failures = 0;

    // Contact per 4-cycle tick period of a key-0 / hold-10 press on B
    // starting from seed 8'hA5 (bit p = period p):
    //   press   : 0, A5[0]=1, 4A[0]=0, 95[0]=1, 2A[0]=0
    //   hold    : 10 x 1
    //   release : 1, A9[0]=1, 53[0]=1, A7[0]=1, 4E[0]=0
    logic [19:0] b_contact_tab;

    always #5 clk = ~clk;

    keypad_emulator #(.TICK_DIV(4), .BOUNCE_TICKS(0)) dut_a (
        .clk(clk), .RSTn(rst_n), .row(row_a), .col(col_a),
        .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_key(a_key),
        .cmd_hold(a_hold), .busy(a_busy), .done(a_done)
    );

    keypad_emulator #(.TICK_DIV(4), .BOUNCE_TICKS(5)) dut_b (
        .clk(clk), .RSTn(rst_n), .row(row_b), .col(col_b),
        .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_key(b_key),
        .cmd_hold(b_hold), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a command on A; returns at cycle 1 (first cycle after accept),
    // before sampling.
    task automatic a_cmd(input logic [3:0] key, input logic [15:0] hold);
        @(negedge clk);
        a_valid = 1'b1; a_key = key; a_hold = hold;
        #1 check("a_ready_before_accept", 16'(a_ready), 16'd1);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    // Full key-0 / hold-10 press on B, checked cycle by cycle.
    task automatic run_b(input string name);
        int         dones = 0;
        logic [3:0] exp_col;
        @(negedge clk);
        b_valid = 1'b1; b_key = 4'h0; b_hold = 16'd10;
        #1 check("b_ready_before_accept", 16'(b_ready), 16'd1);
        @(negedge clk);
        b_valid = 1'b0;
        for (int k = 1; k <= 81; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            exp_col = (k <= 80 && b_contact_tab[(k - 1) / 4]) ? 4'b1110 : 4'hF;
            check($sformatf("%s_col_c%0d", name, k), 16'(col_b), 16'(exp_col));
            check($sformatf("%s_busy_c%0d", name, k), 16'(b_busy), 16'(k <= 80));
            check($sformatf("%s_done_c%0d", name, k), 16'(b_done), 16'(k == 80));
            dones += int'(b_done);
        end
        check($sformatf("%s_ready_end", name), 16'(b_ready), 16'd1);
        $display("txn %s: key=0 hold=10 bounce=5 done_pulses=%0d", name, dones);
    endtask

    initial begin
        int         dones;
        logic [3:0] exp_col;
        int         rsel;

        b_contact_tab = 20'h7FFEA;
        rst_n   = 1'b0;
        row_a   = 4'hF;  row_b  = 4'b1110;
        a_valid = 1'b0;  b_valid = 1'b0;
        a_key   = '0;    b_key   = '0;
        a_hold  = '0;    b_hold  = '0;

        // Reset state
        #1;
        check("rst_a_col",   16'(col_a),   16'hF);
        check("rst_b_col",   16'(col_b),   16'hF);
        check("rst_a_ready", 16'(a_ready), 16'd1);
        check("rst_b_busy",  16'(b_busy),  16'd0);
        check("rst_a_done",  16'(a_done),  16'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // A: key 6 (row 1, column 2), hold 3, rotating single-low row.
        // Row 1 selected is row = 4'b1101; column 2 closed is col = 4'b1011.
        a_cmd(4'h6, 16'd3);
        dones = 0;
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) @(negedge clk);
            rsel  = k % 4;
            row_a = ~(4'b0001 << rsel);
            #1;
            exp_col = (k <= 12 && rsel == 1) ? 4'b1011 : 4'hF;
            check($sformatf("a_rot_col_c%0d", k), 16'(col_a), 16'(exp_col));
            check($sformatf("a_rot_done_c%0d", k), 16'(a_done), 16'(k == 12));
            check($sformatf("a_rot_ready_c%0d", k), 16'(a_ready), 16'(k == 13));
            dones += int'(a_done);
        end
        $display("txn a_rotate: key=6 hold=3 done_pulses=%0d", dones);

        // A: key F, hold 0 (acts as 1 tick), all rows low.
        row_a = 4'h0;
        a_cmd(4'hF, 16'd0);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            exp_col = (k <= 4) ? 4'b0111 : 4'hF;
            check($sformatf("a_h0_col_c%0d", k), 16'(col_a), 16'(exp_col));
            check($sformatf("a_h0_busy_c%0d", k), 16'(a_busy), 16'(k <= 4));
            check($sformatf("a_h0_done_c%0d", k), 16'(a_done), 16'(k == 4));
        end
        $display("txn a_hold0: key=F hold=0 rows=all-low");

        // A: second command offered during HOLD must be ignored.
        row_a = 4'b1110;
        a_cmd(4'h3, 16'd3);
        dones = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 2) begin a_valid = 1'b1; a_key = 4'h5; a_hold = 16'd7; end
            if (k == 6) a_valid = 1'b0;
            #1;
            exp_col = (k <= 12) ? 4'b0111 : 4'hF;
            check($sformatf("a_ign_col_c%0d", k), 16'(col_a), 16'(exp_col));
            check($sformatf("a_ign_ready_c%0d", k), 16'(a_ready), 16'(k > 12));
            check($sformatf("a_ign_busy_c%0d", k), 16'(a_busy), 16'(k <= 12));
            dones += int'(a_done);
        end
        check("a_ign_done_count", 16'(dones), 16'd1);
        $display("txn a_ignore: key=3 hold=3 extra_cmd_ignored done_pulses=%0d", dones);

        // B: full chattering press from the reset seed.
        run_b("b_seq1");

        // B: reset in the middle of HOLD.
        @(negedge clk);
        b_valid = 1'b1; b_key = 4'h0; b_hold = 16'd10;
        @(negedge clk);
        b_valid = 1'b0;
        for (int k = 2; k <= 30; k++) @(negedge clk);
        #1 check("b_mid_hold_col", 16'(col_b), 16'b1110);
        #1 rst_n = 1'b0;
        #1;
        check("b_rst_col_async", 16'(col_b),   16'hF);
        check("b_rst_busy",      16'(b_busy),  16'd0);
        check("b_rst_ready",     16'(b_ready), 16'd1);
        check("b_rst_done",      16'(b_done),  16'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            #1;
            dones += int'(b_done);
            check($sformatf("b_post_rst_busy_c%0d", k), 16'(b_busy), 16'd0);
        end
        check("b_post_rst_done_count", 16'(dones), 16'd0);
        $display("txn b_reset_mid_hold: sequence discarded");

        // B: next press must chatter from the reseeded LFSR again.
        run_b("b_seq2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
